instr_encoder: RTL

//  Encodes symbolic MIPS instruction requests (mnemonic + fields) into 32-bit machine words.

---
 rtl/mips_defs.sv | 34 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/instr_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// MIPS opcode/func field values shared with the main controller, plus the
// mnemonic codes the instruction encoder accepts.
package mips_defs;

    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] OpLw      = 6'h23;
    localparam logic [5:0] OpSw      = 6'h2B;

    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnOr   = 6'h25;

    typedef enum logic [3:0] {
        MnNop  = 4'd0,
        MnAddu = 4'd1,
        MnSubu = 4'd2,
        MnOr   = 4'd3,
        MnOri  = 4'd4,
        MnLw   = 4'd5,
        MnSw   = 4'd6,
        MnBeq  = 4'd7,
        MnLui  = 4'd8,
        MnJ    = 4'd9,
        MnJal  = 4'd10,
        MnJr   = 4'd11
    } mnem_e;

endpackage

// File: rtl/sync_fifo.sv
// Registered show-ahead FIFO: rdata always shows the head entry.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS instruction requests into machine words and streams them
// through a FIFO into instruction memory at consecutive word addresses.
module instr_encoder
    import mips_defs::*;
#(
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h3000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              addr_clr,
    input  logic              im_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       wr_count,
    output logic              err
);

    logic [31:0]            enc_word;
    logic                   enc_legal;
    logic                   accept, push, pop;
    logic [31:0]            fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ADDR_W-1:0]      addr_q;
    logic [15:0]            wr_count_q;
    logic                   err_q;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_mnem)
            MnNop:  enc_word = '0;
            MnAddu: enc_word = {OpSpecial, in_rs, in_rt, in_rd, 5'b0, FnAddu};
            MnSubu: enc_word = {OpSpecial, in_rs, in_rt, in_rd, 5'b0, FnSubu};
            MnOr:   enc_word = {OpSpecial, in_rs, in_rt, in_rd, 5'b0, FnOr};
            MnOri:  enc_word = {OpOri, in_rs, in_rt, in_imm};
            MnLw:   enc_word = {OpLw, in_rs, in_rt, in_imm};
            MnSw:   enc_word = {OpSw, in_rs, in_rt, in_imm};
            MnBeq:  enc_word = {OpBeq, in_rs, in_rt, in_imm};
            MnLui:  enc_word = {OpLui, 5'b0, in_rt, in_imm};
            MnJ:    enc_word = {OpJ, in_target};
            MnJal:  enc_word = {OpJal, in_target};
            MnJr:   enc_word = {OpSpecial, in_rs, 15'b0, FnJr};
            default: enc_legal = 1'b0;
        endcase
    end

    // Illegal requests still complete the handshake; they only raise err.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign pop      = im_we && im_ready;

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign im_we    = (fifo_count != '0);
    assign im_wdata = fifo_empty ? 32'h0 : fifo_rdata;
    assign im_addr  = addr_q;
    assign wr_count = wr_count_q;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= BASE_ADDR;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && !enc_legal;
            // A same-cycle pop still writes at the old address; the clear wins afterwards.
            if (addr_clr) begin
                addr_q <= BASE_ADDR;
            end else if (pop) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
            if (pop && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

endmodule
